uart_rx_param: RTL and testbench

Parametrised UART receiver, the next generation of the fixed 8N1 receiver.
- Runtime baud divisor and oversample rate.
- Configurable data width, optional parity (even/odd) and 1 or 2 stop bits.
- 3-sample majority voting at bit centre.
- Parity, framing, overrun and break detection.
- Small receive FIFO with a valid/ready pop interface towards the host-side logic.

---
 rtl/uart_rx_param.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised UART receiver. Runtime baud divisor, configurable
//            data width, optional parity, 1/2 stop bits, 3-sample majority
//            vote, error/break detection and a small receive FIFO with a
//            valid/ready pop interface.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 rx_idle
);

  localparam int SUB_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_BITS);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int ENT_W    = DATA_BITS + 2;
  localparam int IDLE_MAX = IDLE_BITS * OVERSAMPLE;
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

  localparam logic [SUB_W-1:0]  SAMPLE_A = SUB_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SUB_W-1:0]  SAMPLE_B = SUB_W'(OVERSAMPLE / 2);
  localparam logic [SUB_W-1:0]  SAMPLE_C = SUB_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  // The tick that detects the edge is counted as tick 1 of the start bit: the
  // true edge lies between the previous tick and this one, plus the
  // synchroniser delay, so this keeps the vote centred on each bit.
  localparam logic [SUB_W-1:0]  SUB_FIRST = SUB_W'(2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_MAX);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK_WAIT
  } state_t;

  state_t               state, state_nx;
  logic [DIV_WIDTH-1:0] tick_cnt, div_lat;
  logic                 tick;
  logic                 sync1, sync2, rx_s, rx_prev;
  logic [1:0]           sync_fill;
  logic [SUB_W-1:0]     sub_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 samp_a, samp_b, maj, at_mid, at_last;
  logic                 par_bit, perr_acc, ferr_acc;
  logic                 par_en_l, par_odd_l, two_stop_l;
  logic                 frame_done, frame_ferr, brk;
  logic [IDLE_W-1:0]    idle_cnt;

  logic [ENT_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_nx;
  logic [CNT_W-1:0]     count, count_nx;
  logic                 pop, full, push_ok, drop;
  logic [ENT_W-1:0]     push_word, head_word;

  assign tick = (tick_cnt == div_lat);

  // Free-running baud tick counter; a new divisor is picked up only at wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      div_lat  <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      div_lat  <= baud_div;
    end else begin
      tick_cnt <= tick_cnt + DIV_WIDTH'(1);
    end
  end

  // Two-flop synchroniser; sync_fill marks when reset-value ones have flushed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_fill <= '0;
    end else begin
      sync1     <= rx;
      sync2     <= sync1;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  assign rx_s = sync2;

  // Line value at the previous tick; starts low so a line held low through
  // reset release never looks like a falling edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      rx_prev <= 1'b0;
    else if (tick && sync_fill[1])   rx_prev <= rx_s;
  end

  assign at_mid  = (sub_cnt == SAMPLE_C);
  assign at_last = (sub_cnt == SUB_LAST);
  assign maj     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  // Capture the first two votes; the third is the live sample at SAMPLE_C
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
    end else if (tick) begin
      if (sub_cnt == SAMPLE_A) samp_a <= rx_s;
      if (sub_cnt == SAMPLE_B) samp_b <= rx_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic plus frame-end and break strobes
  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    frame_ferr = ferr_acc;
    brk        = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE:   if (rx_prev && !rx_s) state_nx = S_START;
        S_START: begin
          if (at_mid && maj) state_nx = S_IDLE;
          else if (at_last)  state_nx = S_DATA;
        end
        S_DATA:   if (at_last && bit_cnt == BIT_LAST)
                    state_nx = par_en_l ? S_PARITY : S_STOP1;
        S_PARITY: if (at_last) state_nx = S_STOP1;
        S_STOP1: begin
          if (at_mid) begin
            if (!maj && shreg == '0 && (!par_en_l || !par_bit)) begin
              brk      = 1'b1;
              state_nx = S_BREAK_WAIT;
            end else if (!two_stop_l) begin
              frame_done = 1'b1;
              frame_ferr = ~maj;
              state_nx   = S_IDLE;
            end
          end else if (at_last && two_stop_l) begin
            state_nx = S_STOP2;
          end
        end
        S_STOP2: begin
          if (at_mid) begin
            frame_done = 1'b1;
            frame_ferr = ferr_acc | ~maj;
            state_nx   = S_IDLE;
          end
        end
        S_BREAK_WAIT: if (rx_s) state_nx = S_IDLE;
        default:      state_nx = S_IDLE;
      endcase
    end
  end

  // Per-frame datapath: bit timing, shifter, latched config and error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      par_en_l   <= 1'b0;
      par_odd_l  <= 1'b0;
      two_stop_l <= 1'b0;
    end else if (tick) begin
      if (state == S_IDLE) begin
        sub_cnt <= '0;
        if (state_nx == S_START) begin
          sub_cnt    <= SUB_FIRST;
          bit_cnt    <= '0;
          par_bit    <= 1'b0;
          perr_acc   <= 1'b0;
          ferr_acc   <= 1'b0;
          par_en_l   <= parity_en;
          par_odd_l  <= parity_odd;
          two_stop_l <= two_stop;
        end
      end else if (state == S_BREAK_WAIT) begin
        sub_cnt <= '0;
      end else begin
        sub_cnt <= at_last ? '0 : sub_cnt + SUB_W'(1);
        if (at_mid) begin
          case (state)
            S_DATA:   shreg <= {maj, shreg[DATA_BITS-1:1]};
            S_PARITY: begin
              par_bit  <= maj;
              perr_acc <= (((^shreg) ^ maj) != par_odd_l);
            end
            S_STOP1:  ferr_acc <= ~maj;
            default:  ;
          endcase
        end
        if (at_last && state == S_DATA) bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  // Idle timer: counts ticks of high line while no frame is in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           idle_cnt <= '0;
    else if (state != S_IDLE || !rx_s)    idle_cnt <= '0;
    else if (tick && idle_cnt != IDLE_SAT) idle_cnt <= idle_cnt + IDLE_W'(1);
  end

  assign rx_idle = (idle_cnt == IDLE_SAT);

  // FIFO control; a full FIFO still accepts a push when the head leaves
  assign push_word = {perr_acc, frame_ferr, shreg};
  assign pop       = rx_valid && rx_ready;
  assign full      = (count == CNT_FULL);
  assign push_ok   = frame_done && (!full || pop);
  assign drop      = frame_done && full && !pop;
  assign rd_nx     = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign count_nx  = count + CNT_W'(push_ok) - CNT_W'(pop);
  // The next head is the word being written when it lands at the read slot
  assign head_word = (push_ok && wr_ptr == rd_nx) ? push_word : mem[rd_nx];

  // FIFO storage (contents need no reset, occupancy is tracked separately)
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers, registered head outputs and one-cycle status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rx_perr   <= 1'b0;
      rx_ferr   <= 1'b0;
      overrun   <= 1'b0;
      break_det <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr   <= rd_nx;
      count    <= count_nx;
      rx_valid <= (count_nx != '0);
      if (count_nx != '0) {rx_perr, rx_ferr, rx_data} <= head_word;
      overrun   <= drop;
      break_det <= brk;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Brief    : Self-checking bench for uart_rx_param. Expected words are queued
//            as frames are driven and compared when the DUT hands them out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

  localparam int BIT_CLKS = 64;   // baud_div=3, OVERSAMPLE=16

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, two_stop;
  logic [7:0]  rx_data;
  logic        rx_perr, rx_ferr, rx_valid, rx_ready;
  logic        overrun, break_det, rx_idle;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   valid_cycles = 0;
  int   ovr_cnt = 0;
  int   brk_cnt = 0;
  int   vc0, ovr0, brk0, lat, idl;

  always #5 clk = ~clk;

  uart_rx_param dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .rx_data    (rx_data),
    .rx_perr    (rx_perr),
    .rx_ferr    (rx_ferr),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .overrun    (overrun),
    .break_det  (break_det),
    .rx_idle    (rx_idle)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_perr(input logic [7:0] d, input logic pb, input logic odd);
    return (((^d) ^ pb) != odd);
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    exp_q.push_back(e);
  endtask

  // Drive one frame; gpos selects a frame bit that gets a 4-clock low pulse
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic s1, input logic s2, input logic two,
                            input int gpos);
    logic bits [12];
    int   n;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
    if (pen) begin bits[n] = pbit; n++; end
    bits[n] = s1; n++;
    if (two) begin bits[n] = s2; n++; end
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        @(negedge clk);
        rx = (k == gpos && c >= 30 && c < 34) ? 1'b0 : bits[k];
      end
    end
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Output monitor: counts pulses and compares every popped word
  always @(negedge clk) begin
    if (rx_valid)  valid_cycles++;
    if (overrun)   ovr_cnt++;
    if (break_det) brk_cnt++;
    if (rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", rx_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_data", rx_data, mon_e.data);
        check("rx_perr", rx_perr, mon_e.perr);
        check("rx_ferr", rx_ferr, mon_e.ferr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; rx = 1'b1; baud_div = 16'd3;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {rx_data, rx_perr, rx_ferr, rx_valid, overrun, break_det, rx_idle}, 0);
    reset = 1'b1;
    idle_bits(3);
    check("idle_after_reset", rx_idle, 1);

    // 8N1 0xA5 with push latency window
    vc0 = valid_cycles;
    push_exp(8'hA5, 1'b0, 1'b0);
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      begin
        lat = 0;
        @(negedge clk);
        while (!rx_valid && lat < 700) begin
          @(posedge clk);
          lat++;
          #1;
        end
        check("t1_latency_window", (lat >= 600 && lat <= 615), 1);
      end
    join
    idle_bits(1);
    wait_drain("t1_drain", 200);
    check("t1_one_valid_cycle", valid_cycles - vc0, 1);

    // Parity
    parity_en = 1'b1; parity_odd = 1'b1;
    push_exp(8'h03, exp_perr(8'h03, 1'b1, 1'b1), 1'b0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    idle_bits(1);
    push_exp(8'h03, exp_perr(8'h03, 1'b0, 1'b1), 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    idle_bits(1);
    parity_odd = 1'b0;
    push_exp(8'h07, exp_perr(8'h07, 1'b1, 1'b0), 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    idle_bits(1);
    parity_en = 1'b0;
    wait_drain("t2_drain", 200);

    // Framing errors, one and two stop bits
    brk0 = brk_cnt;
    push_exp(8'h55, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    idle_bits(1);
    two_stop = 1'b1;
    push_exp(8'hC3, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    idle_bits(1);
    push_exp(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
    idle_bits(1);
    two_stop = 1'b0;
    wait_drain("t3_drain", 200);
    check("t3_no_break", brk_cnt - brk0, 0);

    // Glitch rejection and majority vote
    vc0 = valid_cycles;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    idle_bits(3);
    check("t4_glitch_no_frame", valid_cycles - vc0, 0);
    push_exp(8'hFF, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4);
    idle_bits(1);
    push_exp(8'hF0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6);
    idle_bits(1);
    wait_drain("t4_drain", 200);

    // Overrun with back-to-back frames
    set_ready(1'b0);
    ovr0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) push_exp(8'(i), 1'b0, 1'b0);
      send_frame(8'(i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    end
    idle_bits(1);
    check("t5_overrun_once", ovr_cnt - ovr0, 1);
    check("t5_valid_held", rx_valid, 1);
    check("t5_head_data", rx_data, 8'h01);
    set_ready(1'b1);
    wait_drain("t5_drain", 50);
    @(negedge clk);
    check("t5_valid_fell", rx_valid, 0);

    // Break detection and idle timing
    brk0 = brk_cnt;
    vc0  = valid_cycles;
    rx   = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge clk);
    check("t6_idle_low_during_break", rx_idle, 0);
    rx  = 1'b1;
    idl = 0;
    while (!rx_idle && idl < 400) begin
      @(posedge clk);
      idl++;
      #1;
    end
    check("t6_idle_delay_window", (idl >= 124 && idl <= 140), 1);
    check("t6_break_once", brk_cnt - brk0, 1);
    check("t6_break_no_push", valid_cycles - vc0, 0);

    // Reset mid-frame with a word waiting in the FIFO
    set_ready(1'b0);
    send_frame(8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    idle_bits(1);
    check("t7_word_waiting", rx_valid, 1);
    brk0 = brk_cnt;
    ovr0 = ovr_cnt;
    rx = 1'b0;
    repeat (4 * BIT_CLKS) @(negedge clk);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    check("t7_reset_outputs",
          {rx_data, rx_perr, rx_ferr, rx_valid, overrun, break_det, rx_idle}, 0);
    reset = 1'b1;
    set_ready(1'b1);
    idle_bits(2);
    check("t7_fifo_emptied", rx_valid, 0);
    check("t7_no_pulses", (brk_cnt - brk0) + (ovr_cnt - ovr0), 0);
    push_exp(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    idle_bits(1);
    wait_drain("t7_drain", 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
